// File: rtl/alien_object_manager.sv
// Alien slot manager: spawns, advances, animates and removes aliens in a sorted slot array.
// Optional saturating hit counter output enabled by defining ALIEN_MGR_KILL_COUNT_EN.

package alien_pkg;

    typedef struct packed {
        logic       _active;
        logic [3:0] _r;
        logic [1:0] _quadrant;
        logic [1:0] _type;
        logic [1:0] _frame_num;
    } AlienData;

endpackage

module alien_object_manager
    import alien_pkg::*;
#(
    parameter int OBJ_LIMIT = 8,
    parameter int R_MAX     = 15,
    parameter int FRAME_DIV = 4,
    localparam int CW = $clog2(OBJ_LIMIT + 1)
) (
    input  logic          clk_25MHz,
    input  logic          rst_n,
    input  logic          game_tick,
    input  logic          spawn_valid,
    output logic          spawn_ready,
    input  logic [1:0]    spawn_quadrant,
    input  logic [1:0]    spawn_type,
    input  logic          kill_valid,
    output logic          kill_ready,
    input  logic [1:0]    kill_quadrant,
    output logic          kill_hit,
    output logic          kill_miss,
    output logic          player_hit,
    output logic [1:0]    hit_quadrant,
    output logic [CW-1:0] alien_count,
`ifdef ALIEN_MGR_KILL_COUNT_EN
    output logic [7:0]    kill_count,
`endif
    output AlienData      obj_data [OBJ_LIMIT]
);

    localparam int IW = (OBJ_LIMIT > 1) ? $clog2(OBJ_LIMIT) : 1;
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    AlienData      slots_q [OBJ_LIMIT];
    AlienData      slots_d [OBJ_LIMIT];
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] div_q, div_d;
    logic          khit_q, khit_d;
    logic          kmiss_q, kmiss_d;
    logic          phit_q, phit_d;
    logic [1:0]    hq_q, hq_d;

    logic          top_at_rmax;
    logic          kfound;
    logic [IW-1:0] kidx;
    logic          do_tick, do_kill, do_spawn;
    logic          div_wrap;

    // Slots are sorted with unique _r, so any active slot at R_MAX is the last one.
    always_comb begin
        top_at_rmax = 1'b0;
        for (int i = 0; i < OBJ_LIMIT; i++) begin
            if (slots_q[i]._active && slots_q[i]._r == 4'(R_MAX))
                top_at_rmax = 1'b1;
        end
    end

    always_comb begin
        kfound = 1'b0;
        kidx   = '0;
        for (int i = 0; i < OBJ_LIMIT; i++) begin
            if (!kfound && slots_q[i]._active &&
                slots_q[i]._quadrant == kill_quadrant) begin
                kfound = 1'b1;
                kidx   = IW'(i);
            end
        end
    end

    assign kill_ready  = !game_tick;
    assign spawn_ready = !game_tick && !kill_valid &&
                         (count_q < CW'(OBJ_LIMIT)) && !top_at_rmax;

    assign do_tick  = game_tick;
    assign do_kill  = kill_valid && kill_ready;
    assign do_spawn = spawn_valid && spawn_ready;
    assign div_wrap = (div_q == DW'(FRAME_DIV - 1));

    always_comb begin
        slots_d = slots_q;
        count_d = count_q;
        div_d   = div_q;
        khit_d  = 1'b0;
        kmiss_d = 1'b0;
        phit_d  = 1'b0;
        hq_d    = hq_q;
        unique case (1'b1)
            do_tick: begin
                if (slots_q[0]._active && slots_q[0]._r == 4'd0) begin
                    for (int i = 0; i < OBJ_LIMIT - 1; i++)
                        slots_d[i] = slots_q[i+1];
                    slots_d[OBJ_LIMIT-1] = '0;
                    count_d = count_q - CW'(1);
                    phit_d  = 1'b1;
                    hq_d    = slots_q[0]._quadrant;
                end
                for (int i = 0; i < OBJ_LIMIT; i++) begin
                    if (slots_d[i]._active) begin
                        slots_d[i]._r = slots_d[i]._r - 4'd1;
                        if (div_wrap)
                            slots_d[i]._frame_num = slots_d[i]._frame_num + 2'd1;
                    end
                end
                div_d = div_wrap ? '0 : div_q + DW'(1);
            end
            do_kill: begin
                if (kfound) begin
                    for (int i = 0; i < OBJ_LIMIT - 1; i++) begin
                        if (i >= int'(kidx))
                            slots_d[i] = slots_q[i+1];
                    end
                    slots_d[OBJ_LIMIT-1] = '0;
                    count_d = count_q - CW'(1);
                    khit_d  = 1'b1;
                    hq_d    = kill_quadrant;
                end else begin
                    kmiss_d = 1'b1;
                end
            end
            do_spawn: begin
                for (int i = 0; i < OBJ_LIMIT; i++) begin
                    if (CW'(i) == count_q) begin
                        slots_d[i]._active    = 1'b1;
                        slots_d[i]._r         = 4'(R_MAX);
                        slots_d[i]._quadrant  = spawn_quadrant;
                        slots_d[i]._type      = spawn_type;
                        slots_d[i]._frame_num = 2'd0;
                    end
                end
                count_d = count_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            for (int i = 0; i < OBJ_LIMIT; i++)
                slots_q[i] <= '0;
            count_q <= '0;
            div_q   <= '0;
            khit_q  <= 1'b0;
            kmiss_q <= 1'b0;
            phit_q  <= 1'b0;
            hq_q    <= 2'd0;
        end else begin
            slots_q <= slots_d;
            count_q <= count_d;
            div_q   <= div_d;
            khit_q  <= khit_d;
            kmiss_q <= kmiss_d;
            phit_q  <= phit_d;
            hq_q    <= hq_d;
        end
    end

`ifdef ALIEN_MGR_KILL_COUNT_EN
    logic [7:0] kc_q, kc_d;

    assign kc_d = (khit_d && kc_q != 8'hFF) ? kc_q + 8'd1 : kc_q;

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n)
            kc_q <= 8'd0;
        else
            kc_q <= kc_d;
    end

    assign kill_count = kc_q;
`endif

    assign obj_data     = slots_q;
    assign alien_count  = count_q;
    assign kill_hit     = khit_q;
    assign kill_miss    = kmiss_q;
    assign player_hit   = phit_q;
    assign hit_quadrant = hq_q;

endmodule
